// File: rtl/corrimiento_nbits_if.sv
// ---------------------------------------------------------------------------
// corrimiento_nbits_if
// Bundle of the control, data and status signals of the corrimiento_nbits
// shift/rotate register. Clock and reset are kept outside as plain ports.
//
// Signals:
//   enable    single-step request (one operation per edge while idle)
//   mode      operation select (hold/shl/shr/rol/ror/load)
//   in        serial input bit
//   load_data parallel load value
//   start     burst request
//   count     burst length
//   Out       register contents
//   sout      last bit expelled by a shift or rotate
//   busy      burst in progress (RUN or DONE)
//   done      one-cycle burst completion pulse
//
// Modports:
//   master  drives requests, observes status (testbench / controller side)
//   slave   the register block itself
// ---------------------------------------------------------------------------
interface corrimiento_nbits_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
);
    logic             enable;
    logic [2:0]       mode;
    logic             in;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] Out;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output enable, mode, in, load_data, start, count,
        input  Out, sout, busy, done
    );

    modport slave (
        input  enable, mode, in, load_data, start, count,
        output Out, sout, busy, done
    );
endinterface

// File: rtl/corrimiento_nbits.sv
// ---------------------------------------------------------------------------
// corrimiento_nbits
// WIDTH-bit shift/rotate register with single-step operation and a counted
// burst mode controlled by a small IDLE/RUN/DONE state machine.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rst   asynchronous active-high reset
//   bus   corrimiento_nbits_if.slave (enable, mode, in, load_data, start,
//         count in; Out, sout, busy, done out)
//
// Modes: 000 hold, 001 shift up, 010 shift down, 011 rotate up,
//        100 rotate down, 101 parallel load, 110/111 hold.
// ---------------------------------------------------------------------------
module corrimiento_nbits #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    corrimiento_nbits_if.slave   bus
);

    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sout_q, sout_d;

    // Operation request for this edge: either a single step from IDLE
    // (using the live mode) or one burst step in RUN (using the latched mode)
    logic             do_op;
    logic [2:0]       op_mode;

    // State register plus all datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mode_q  <= 3'b000;
            out_q   <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
        end
    end

    // Next-state logic. Start has priority over enable in IDLE, and every
    // request input is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        do_op   = 1'b0;
        op_mode = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        mode_d  = bus.mode;
                        rem_d   = bus.count;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else if (bus.enable) begin
                    do_op   = 1'b1;
                    op_mode = bus.mode;
                end
            end
            RUN: begin
                // The step performed while rem_q==1 is the last of the burst
                do_op   = 1'b1;
                op_mode = mode_q;
                rem_d   = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: hold and load leave sout untouched, shifts and rotates
    // capture the expelled bit
    always_comb begin
        out_d  = out_q;
        sout_d = sout_q;
        if (do_op) begin
            case (op_mode)
                MODE_SHL: begin
                    out_d  = {out_q[WIDTH-2:0], bus.in};
                    sout_d = out_q[WIDTH-1];
                end
                MODE_SHR: begin
                    out_d  = {bus.in, out_q[WIDTH-1:1]};
                    sout_d = out_q[0];
                end
                MODE_ROL: begin
                    out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                    sout_d = out_q[WIDTH-1];
                end
                MODE_ROR: begin
                    out_d  = {out_q[0], out_q[WIDTH-1:1]};
                    sout_d = out_q[0];
                end
                MODE_LOAD: begin
                    out_d  = bus.load_data;
                end
                default: begin
                    out_d  = out_q;
                end
            endcase
        end
    end

    assign bus.Out  = out_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

endmodule

// File: doc/corrimiento_nbits.md
CORRIMIENTO_NBITS -- requirements
Module: corrimiento_nbits

Interface
REQ-001 Parameter WIDTH, default 10, register width in bits (>=2).
REQ-002 Parameter CNT_W, default 4, width of the burst shift count.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  single-step request; one operation per edge while IDLE.
REQ-006 mode  input  3  operation select: 000 hold, 001 shift up, 010 shift down, 011 rotate up, 100 rotate down, 101 parallel load, 110/111 hold.
REQ-007 in  input  1  serial input bit.
REQ-008 load_data  input  WIDTH  parallel load value.
REQ-009 start  input  1  burst request, sampled only in IDLE.
REQ-010 count  input  CNT_W  number of operations in the burst.
REQ-011 Out  output  WIDTH  register contents.
REQ-012 sout  output  1  registered copy of the bit expelled by the most recent shift or rotate.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 done  output  1  one-cycle pulse at burst completion.

Function
REQ-015 Shift up SHALL produce Out <= {Out[WIDTH-2:0], in} and sout <= Out[WIDTH-1].
REQ-016 Shift down SHALL produce Out <= {in, Out[WIDTH-1:1]} and sout <= Out[0].
REQ-017 Rotate up SHALL produce Out <= {Out[WIDTH-2:0], Out[WIDTH-1]} and sout <= Out[WIDTH-1].
REQ-018 Rotate down SHALL produce Out <= {Out[0], Out[WIDTH-1:1]} and sout <= Out[0].
REQ-019 Parallel load SHALL set Out <= load_data; hold and load SHALL leave sout unchanged.
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 In IDLE, if start=1 and count!=0, the block SHALL latch mode and count into internal registers and go to RUN, with no operation on that edge.
REQ-022 In IDLE, if start=1 and count=0, the block SHALL go directly to DONE with Out unchanged.
REQ-023 In IDLE, if start=0 and enable=1, the block SHALL perform one mode operation on that edge.
REQ-024 When start=1 and enable=1 in the same IDLE cycle, start SHALL win and no single-step operation SHALL occur.
REQ-025 In RUN, the block SHALL perform the latched-mode operation on every edge, using the live value of in, and decrement the remaining count.
REQ-026 In RUN, on the edge where the remaining count is 1, the block SHALL perform the last operation and go to DONE.
REQ-027 A burst of N SHALL therefore perform exactly N operations on the N edges following the start edge.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 start, enable, mode and count SHALL be ignored while busy=1.
REQ-030 count = 2^CNT_W-1 SHALL perform the maximum burst with no wrap of the remaining counter.

Reset
REQ-031 While rst=1, asynchronously: Out=0 (all WIDTH bits), sout=0, busy=0, done=0, state=IDLE, remaining count=0, latched mode=000.
REQ-032 Reset during RUN or DONE SHALL abort the burst with no done pulse; operation resumes from IDLE on the first edge after rst falls.

Verification (WIDTH=10, CNT_W=4)
REQ-033 Bench SHALL check reset: rst raised between edges with Out=0x3FF -> Out=0 and busy=0 before the next edge.
REQ-034 Bench SHALL check single step: load 0x2AB (mode 101, enable), then mode 001, in=1, enable for 1 cycle -> Out=0x157, sout=1.
REQ-035 Bench SHALL check rotate burst: Out=0x001, start with mode 100 and count=3 -> Out=0x200, 0x100, 0x080 on edges 1-3 after the start edge; done=1 in the following cycle only; busy=1 for 4 cycles.
REQ-036 Bench SHALL check zero count: start with count=0 -> done pulses in the next cycle, Out unchanged, busy=1 for that single cycle.
REQ-037 Bench SHALL check ignored requests: during a count=5 shift-down burst, pulse start and enable with mode=101 -> exactly 5 shift-downs, no load, a single done pulse.
REQ-038 Bench SHALL check abort: count=8 shift-up burst with in=1, rst asserted after 3 shifts -> Out=0, no done pulse, and a following enable step works normally.
